sram_req_arbiter: RTL and testbench

Two-master to one-slave arbiter for the SRAM-like request interface in front of the AXI bridge. Instruction fetch (master 0) and data access (master 1) share one slave port. The block holds each grant stable across a stalled handshake and prevents instruction starvation. It also blocks data reads while any data write is outstanding, and routes each in-order `s_data_ok` response back to its requester through an order FIFO.

---
 rtl/sram_bus_pkg.sv | 26 ++
 rtl/ord_fifo.sv | 67 ++++++
 rtl/sram_req_arbiter.sv | 145 ++++++++++++++
 tb/tb_sram_req_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bus_pkg.sv
// Shared types for the SRAM-like request bus: request payload, order-FIFO
// entry, master source ids and the arbiter lock state.
package sram_bus_pkg;

    localparam logic SRC_INST = 1'b0;
    localparam logic SRC_DATA = 1'b1;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } sram_req_t;

    typedef struct packed {
        logic src;
        logic wr;
    } ord_ent_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/ord_fifo.sv
// Synchronous order FIFO remembering {src, wr} of each accepted transfer so
// in-order responses can be routed back. Pop on empty is ignored.
module ord_fifo
    import sram_bus_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  ord_ent_t               push_ent,
    input  logic                   pop,
    output ord_ent_t               head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ord_ent_t        mem_q [DEPTH];
    ord_ent_t        mem_d [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_ent;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Two-master (inst/data) to one-slave arbiter with grant lock across stalls,
// inst anti-starvation, read-after-write blocking and in-order response routing.
module sram_req_arbiter
    import sram_bus_pkg::*;
#(
    parameter int MAX_OUT    = 4,
    parameter int STARVE_LIM = 3
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     m0_req,
    input  logic                     m0_wr,
    input  logic [1:0]               m0_size,
    input  logic [31:0]              m0_addr,
    input  logic [3:0]               m0_wstrb,
    input  logic [31:0]              m0_wdata,
    output logic                     m0_addr_ok,
    output logic                     m0_data_ok,
    output logic [31:0]              m0_rdata,
    input  logic                     m1_req,
    input  logic                     m1_wr,
    input  logic [1:0]               m1_size,
    input  logic [31:0]              m1_addr,
    input  logic [3:0]               m1_wstrb,
    input  logic [31:0]              m1_wdata,
    output logic                     m1_addr_ok,
    output logic                     m1_data_ok,
    output logic [31:0]              m1_rdata,
    output logic                     s_req,
    output logic                     s_wr,
    output logic [1:0]               s_size,
    output logic [31:0]              s_addr,
    output logic [3:0]               s_wstrb,
    output logic [31:0]              s_wdata,
    input  logic                     s_addr_ok,
    input  logic                     s_data_ok,
    input  logic [31:0]              s_rdata,
    output logic [$clog2(MAX_OUT):0] outstanding,
    output logic                     resp_err
);

    localparam int CW = $clog2(MAX_OUT) + 1;
    localparam int SW = $clog2(STARVE_LIM + 1);

    arb_state_e       state_q, state_d;
    logic             lock_src_q, lock_src_d;
    logic [SW-1:0]    starve_cnt_q, starve_cnt_d;
    logic [CW-1:0]    wr_pend_q, wr_pend_d;
    logic             resp_err_q, resp_err_d;

    sram_req_t [1:0]  mreq;
    sram_req_t        sel;
    ord_ent_t         head;
    logic             fifo_full, fifo_empty;
    logic             m0_elig, m1_elig, idle_src, sel_src, xfer, pop_ok;

    assign mreq[SRC_INST] = {m0_wr, m0_size, m0_addr, m0_wstrb, m0_wdata};
    assign mreq[SRC_DATA] = {m1_wr, m1_size, m1_addr, m1_wstrb, m1_wdata};

    // Full is registered occupancy, so a same-cycle pop never frees a slot early.
    assign m0_elig  = m0_req && !fifo_full;
    assign m1_elig  = m1_req && (m1_wr || wr_pend_q == '0) && !fifo_full;
    assign idle_src = (m1_elig && !(starve_cnt_q == SW'(STARVE_LIM) && m0_elig))
                      ? SRC_DATA : SRC_INST;

    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;
    assign resp_err = resp_err_q;

    ord_fifo #(
        .DEPTH(MAX_OUT)
    ) u_ord_fifo (
        .clk      (clk),
        .resetn   (resetn),
        .push     (xfer),
        .push_ent ({sel_src, s_wr}),
        .pop      (s_data_ok),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (outstanding)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            lock_src_q   <= SRC_INST;
            starve_cnt_q <= '0;
            wr_pend_q    <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_src_q   <= lock_src_d;
            starve_cnt_q <= starve_cnt_d;
            wr_pend_q    <= wr_pend_d;
            resp_err_q   <= resp_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        lock_src_d   = lock_src_q;
        starve_cnt_d = starve_cnt_q;
        resp_err_d   = resp_err_q | (s_data_ok && fifo_empty);
        case (state_q)
            ST_IDLE: begin
                if (s_req && !s_addr_ok) begin
                    state_d    = ST_LOCKED;
                    lock_src_d = sel_src;
                end
            end
            ST_LOCKED: begin
                if (s_addr_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Counts data grants that bypassed a waiting inst request.
        if (!m0_req || (xfer && sel_src == SRC_INST)) begin
            starve_cnt_d = '0;
        end else if (xfer && starve_cnt_q != SW'(STARVE_LIM)) begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
        wr_pend_d = wr_pend_q + CW'(xfer && s_wr) - CW'(pop_ok && head.wr);
    end

    always_comb begin
        sel_src    = (state_q == ST_LOCKED) ? lock_src_q : idle_src;
        sel        = mreq[sel_src];
        s_req      = (sel_src == SRC_DATA) ? m1_elig : m0_elig;
        s_wr       = sel.wr;
        s_size     = sel.size;
        s_addr     = sel.addr;
        s_wstrb    = sel.wstrb;
        s_wdata    = sel.wdata;
        xfer       = s_req && s_addr_ok;
        m0_addr_ok = xfer && (sel_src == SRC_INST);
        m1_addr_ok = xfer && (sel_src == SRC_DATA);
        pop_ok     = s_data_ok && !fifo_empty;
        m0_data_ok = pop_ok && (head.src == SRC_INST);
        m1_data_ok = pop_ok && (head.src == SRC_DATA);
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench: stimulus pushes expected grants/responses into queues and a
// negedge monitor compares them against the slave and master handshakes.
module tb_sram_req_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_req, m0_wr, m1_req, m1_wr;
    logic [1:0]  m0_size, m1_size, s_size;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, m0_rdata, m1_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
    logic        s_req, s_wr, s_addr_ok, s_data_ok, resp_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [2:0]  outstanding;

    typedef struct {
        logic        src;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } gnt_t;
    typedef struct {
        logic        src;
        logic [31:0] data;
    } rsp_t;

    gnt_t exp_gnt[$];
    rsp_t exp_rsp[$];
    gnt_t g;
    rsp_t r;
    logic [31:0] got;
    int vec_cnt  = 0;
    int miss_cnt = 0;

    always #5 clk = ~clk;

    sram_req_arbiter #(.MAX_OUT(4), .STARVE_LIM(3)) dut (
        .clk(clk), .resetn(resetn),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wstrb(m0_wstrb), .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok),
        .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wstrb(m1_wstrb), .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok),
        .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
        .s_wstrb(s_wstrb), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok),
        .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .outstanding(outstanding), .resp_err(resp_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m0(input logic rq, input logic [31:0] a);
        m0_req = rq; m0_wr = 1'b0; m0_size = 2'd2; m0_addr = a;
        m0_wstrb = 4'h0; m0_wdata = 32'h0;
    endtask

    task automatic m1(input logic rq, input logic w, input logic [31:0] a, input logic [31:0] d);
        m1_req = rq; m1_wr = w; m1_size = 2'd2; m1_addr = a;
        m1_wstrb = w ? 4'hF : 4'h0; m1_wdata = d;
    endtask

    task automatic rsp(input logic v, input logic [31:0] d);
        s_data_ok = v; s_rdata = d;
    endtask

    task automatic eg(input logic src, input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_gnt.push_back('{src, w, a, d});
    endtask

    task automatic er(input logic src, input logic [31:0] d);
        exp_rsp.push_back('{src, d});
    endtask

    // An expected entry exists only in the cycle it is due, so a missing
    // handshake is caught in that cycle rather than at the end.
    always @(negedge clk) begin
        if (resetn) begin
            if ((s_req && s_addr_ok) || exp_gnt.size() != 0) begin
                vec_cnt++;
                if (exp_gnt.size() == 0) begin
                    miss_cnt++;
                    $display("FAIL grant: unexpected m0_aok=%0b m1_aok=%0b addr=%h", m0_addr_ok, m1_addr_ok, s_addr);
                end else begin
                    g = exp_gnt.pop_front();
                    if (!(s_req && s_addr_ok) || (m0_addr_ok == m1_addr_ok) || m1_addr_ok != g.src ||
                        s_wr != g.wr || s_addr != g.addr || s_wdata != g.wdata || s_size != 2'd2 ||
                        s_wstrb != (g.wr ? 4'hF : 4'h0)) begin
                        miss_cnt++;
                        $display("FAIL grant: got req=%0b aok=%0b/%0b wr=%0b addr=%h wdata=%h want src=%0d wr=%0b addr=%h wdata=%h",
                                 s_req, m0_addr_ok, m1_addr_ok, s_wr, s_addr, s_wdata, g.src, g.wr, g.addr, g.wdata);
                    end
                end
            end
            if (m0_data_ok || m1_data_ok || exp_rsp.size() != 0) begin
                vec_cnt++;
                if (exp_rsp.size() == 0) begin
                    miss_cnt++;
                    $display("FAIL resp: unexpected data_ok m0=%0b m1=%0b", m0_data_ok, m1_data_ok);
                end else begin
                    r   = exp_rsp.pop_front();
                    got = r.src ? m1_rdata : m0_rdata;
                    if ((m0_data_ok == m1_data_ok) || m1_data_ok != r.src || got != r.data) begin
                        miss_cnt++;
                        $display("FAIL resp: got dok=%0b/%0b rdata=%h want src=%0d rdata=%h",
                                 m0_data_ok, m1_data_ok, got, r.src, r.data);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        m0(0, 0); m1(0, 0, 0, 0); rsp(0, 0); s_addr_ok = 1'b0;
        step(); step();
        @(negedge clk);
        chk("rst_out", outstanding, 0);
        chk("rst_err", resp_err, 0);
        chk("rst_sreq", s_req, 0);
        chk("rst_aok", {m0_addr_ok, m1_addr_ok, m0_data_ok, m1_data_ok}, 0);
        step(); resetn = 1'b1;
        step();

        // Contention: data wins first, inst next; responses in order
        m0(1, 32'h100); m1(1, 0, 32'h200, 0); s_addr_ok = 1; eg(1, 0, 32'h200, 0);
        @(negedge clk); chk("cont_m0_aok0", m0_addr_ok, 0);
        step(); m1(0, 0, 0, 0); eg(0, 0, 32'h100, 0);
        step(); m0(0, 0); s_addr_ok = 0; rsp(1, 32'hD200); er(1, 32'hD200);
        @(negedge clk); chk("cont_out2", outstanding, 2);
        step(); rsp(1, 32'hD100); er(0, 32'hD100);
        step(); rsp(0, 0);
        @(negedge clk); chk("cont_out0", outstanding, 0);

        // Lock: inst held through 3 stalled cycles despite data request
        step(); m0(1, 32'h300); s_addr_ok = 0;
        @(negedge clk); chk("lock_addr0", s_addr, 32'h300); chk("lock_sreq0", s_req, 1);
        step(); m1(1, 0, 32'h400, 0);
        @(negedge clk); chk("lock_addr1", s_addr, 32'h300);
        step();
        @(negedge clk); chk("lock_addr2", s_addr, 32'h300);
        step(); s_addr_ok = 1; eg(0, 0, 32'h300, 0);
        @(negedge clk); chk("lock_addr3", s_addr, 32'h300);
        step(); m0(0, 0); eg(1, 0, 32'h400, 0);
        step(); m1(0, 0, 0, 0); s_addr_ok = 0; rsp(1, 32'hD300); er(0, 32'hD300);
        step(); rsp(1, 32'hD400); er(1, 32'hD400);
        step(); rsp(0, 0);

        // Starvation: m1,m1,m1,m0,m1
        step(); m0(1, 32'h500); m1(1, 0, 32'h600, 0); s_addr_ok = 1; eg(1, 0, 32'h600, 0);
        step(); m1(1, 0, 32'h604, 0); eg(1, 0, 32'h604, 0); rsp(1, 32'hD600); er(1, 32'hD600);
        step(); m1(1, 0, 32'h608, 0); eg(1, 0, 32'h608, 0); rsp(1, 32'hD604); er(1, 32'hD604);
        step(); m1(1, 0, 32'h60C, 0); eg(0, 0, 32'h500, 0); rsp(1, 32'hD608); er(1, 32'hD608);
        @(negedge clk); chk("starve_m1_aok", m1_addr_ok, 0);
        step(); m0(0, 0); eg(1, 0, 32'h60C, 0); rsp(1, 32'hD500); er(0, 32'hD500);
        step(); m1(0, 0, 0, 0); s_addr_ok = 0; rsp(1, 32'hD60C); er(1, 32'hD60C);
        step(); rsp(0, 0);

        // RAW block: data read waits for write response; inst read passes
        step(); m1(1, 1, 32'h40, 32'h1234_5678); s_addr_ok = 1; eg(1, 1, 32'h40, 32'h1234_5678);
        step(); m1(1, 0, 32'h40, 0);
        @(negedge clk); chk("raw_blk0", s_req, 0);
        step(); m0(1, 32'h80); eg(0, 0, 32'h80, 0);
        step(); m0(0, 0); rsp(1, 32'hFFFF_0000); er(1, 32'hFFFF_0000);
        @(negedge clk); chk("raw_blk1", s_req, 0);
        step(); rsp(1, 32'hD080); er(0, 32'hD080); eg(1, 0, 32'h40, 0);
        step(); m1(0, 0, 0, 0); s_addr_ok = 0; rsp(1, 32'hD040); er(1, 32'hD040);
        step(); rsp(0, 0);

        // Full FIFO: 5th request waits until the cycle after a pop
        step(); m0(1, 32'h700); s_addr_ok = 1; eg(0, 0, 32'h700, 0);
        for (int i = 1; i < 4; i++) begin
            step(); m0(1, 32'h700 + 4 * i); eg(0, 0, 32'h700 + 4 * i, 0);
        end
        step(); m0(1, 32'h710);
        @(negedge clk); chk("full_out4", outstanding, 4); chk("full_sreq0", s_req, 0);
        step(); rsp(1, 32'hD700); er(0, 32'hD700);
        @(negedge clk); chk("full_sreq1", s_req, 0);
        step(); rsp(0, 0); eg(0, 0, 32'h710, 0);
        @(negedge clk); chk("full_out3", outstanding, 3);
        step(); m0(0, 0); s_addr_ok = 0;
        for (int i = 1; i < 5; i++) begin
            step(); rsp(1, 32'hD700 + 4 * i); er(0, 32'hD700 + 4 * i);
        end
        step(); rsp(0, 0);
        @(negedge clk); chk("full_drain", outstanding, 0);

        // Error on empty pop, then reset with 2 outstanding and a lock held
        step(); rsp(1, 32'hBAD0);
        step(); rsp(0, 0);
        @(negedge clk); chk("err_flag", resp_err, 1); chk("err_out", outstanding, 0);
        step(); m0(1, 32'h800); s_addr_ok = 1; eg(0, 0, 32'h800, 0);
        step(); m0(1, 32'h804); eg(0, 0, 32'h804, 0);
        step(); m0(1, 32'h900); s_addr_ok = 0;
        @(negedge clk); chk("pre_rst_out", outstanding, 2); chk("pre_rst_err", resp_err, 1);
        step(); m0(0, 0); resetn = 1'b0;
        step(); resetn = 1'b1;
        @(negedge clk); chk("post_out", outstanding, 0); chk("post_err", resp_err, 0);
        step(); m1(1, 0, 32'hA00, 0); s_addr_ok = 1; eg(1, 0, 32'hA00, 0);
        step(); m1(0, 0, 0, 0); s_addr_ok = 0; rsp(1, 32'hDA00); er(1, 32'hDA00);
        step(); rsp(0, 0);
        @(negedge clk); chk("end_out", outstanding, 0);
        step();
        chk("gnt_q_left", exp_gnt.size(), 0);
        chk("rsp_q_left", exp_rsp.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
